// File: rtl/ct_read_arbiter.sv
// ct_read_arbiter: round-robin ct_mem read-port arbiter with bounded lock and latency-matched return strobes
module ct_read_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int RD_LAT = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]   gnt,
  output logic [AW-1:0]      mem_addr,
  input  logic [DW-1:0]      mem_rddata,
  output logic [DW-1:0]      rd_data,
  output logic [N_REQ-1:0]   rd_valid,
  output logic               busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [IW-1:0] last_id, owner, w;
  logic [CW-1:0] lock_cnt;
  logic lock_owner_valid, locked, any;
  logic [RD_LAT-1:0] pv;
  logic [IW-1:0] pid [RD_LAT];
  assign locked = lock_owner_valid && req[owner] && lock[owner] && lock_cnt < CW'(MAX_LOCK);
  always_comb begin
    w = owner;
    any = locked;
    for (int k = N_REQ; k >= 1; k--) begin
      if (!locked && req[(int'(last_id) + k) % N_REQ]) begin
        w = IW'((int'(last_id) + k) % N_REQ);
        any = 1'b1;
      end
    end
  end
  assign gnt = (any && !rst) ? N_REQ'(1) << w : '0;
  assign mem_addr = (any && !rst) ? addr[w*AW +: AW] : '0;
  assign rd_data = mem_rddata;
  assign rd_valid = (pv[RD_LAT-1] && !rst) ? N_REQ'(1) << pid[RD_LAT-1] : '0;
  assign busy = !rst && (any || |pv);
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= IW'(N_REQ - 1);
      owner <= '0;
      lock_cnt <= '0;
      lock_owner_valid <= 1'b0;
      pv <= '0;
    end else begin
      pv[0] <= any;
      pid[0] <= w;
      for (int s = 1; s < RD_LAT; s++) begin
        pv[s] <= pv[s-1];
        pid[s] <= pid[s-1];
      end
      if (any) begin
        last_id <= w;
        owner <= w;
        lock_owner_valid <= lock[w];
        lock_cnt <= locked ? lock_cnt + 1'b1 : CW'(1);
      end else begin
        lock_owner_valid <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ct_read_arbiter.sv
// tb_ct_read_arbiter: directed vectors plus a per-cycle behavioural model for the arbiter
module tb_ct_read_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] addr_all = {8'h13, 8'h12, 8'h11, 8'h10};
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [3:0] req_a = 4'hF, lock_a = 4'h0, req_b = 4'h0, lock_b = 4'h0;
  logic [3:0] gnt_a, rd_valid_a, gnt_b, rd_valid_b;
  logic [7:0] mem_addr_a, mem_rd_a, rd_data_a, mem_addr_b, mem_rd_b, mb_q, rd_data_b;
  logic busy_a, busy_b;
  int n_pass = 0, n_chk = 0;
  ct_read_arbiter #(.N_REQ(4), .AW(8), .DW(8), .RD_LAT(1), .MAX_LOCK(4)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .lock(lock_a), .addr(addr_all), .gnt(gnt_a),
    .mem_addr(mem_addr_a), .mem_rddata(mem_rd_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a));
  ct_read_arbiter #(.N_REQ(4), .AW(8), .DW(8), .RD_LAT(2), .MAX_LOCK(16)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .lock(lock_b), .addr(addr_all), .gnt(gnt_b),
    .mem_addr(mem_addr_b), .mem_rddata(mem_rd_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b));
  always @(posedge clk) begin
    mem_rd_a <= mem_addr_a ^ 8'hFF;
    mb_q <= mem_addr_b ^ 8'hFF;
    mem_rd_b <= mb_q;
  end
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction
  int m_last = 3, m_owner = 0, m_ov = 0, m_cnt = 0, cyc = 0;
  bit iss [256];
  int iid [256];
  logic [7:0] idat [256];
  function automatic int pick(input logic [3:0] r, input logic [3:0] l);
    if (m_ov != 0 && r[m_owner] && l[m_owner] && m_cnt < 4) return m_owner;
    for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction
  always @(posedge clk) begin
    int w;
    bit hon;
    if (rst_a) begin
      m_last = 3;
      m_ov = 0;
      m_cnt = 0;
      iss[cyc % 256] = 1'b0;
    end else begin
      w = pick(req_a, lock_a);
      hon = m_ov != 0 && req_a[m_owner] && lock_a[m_owner] && m_cnt < 4;
      iss[cyc % 256] = w >= 0;
      if (w >= 0) begin
        iid[cyc % 256] = w;
        idat[cyc % 256] = addr_all[w*8 +: 8] ^ 8'hFF;
        m_last = w;
        m_cnt = hon ? m_cnt + 1 : 1;
        m_ov = int'(lock_a[w]);
        m_owner = w;
      end else begin
        m_ov = 0;
        m_cnt = 0;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    int w, p;
    logic [3:0] eg, ev;
    logic [7:0] ea;
    p = (cyc + 255) % 256;
    w = rst_a ? -1 : pick(req_a, lock_a);
    eg = w >= 0 ? 4'(1 << w) : 4'h0;
    ea = w >= 0 ? addr_all[w*8 +: 8] : 8'h0;
    ev = (!rst_a && iss[p]) ? 4'(1 << iid[p]) : 4'h0;
    chk("model_gnt", 32'(gnt_a), 32'(eg));
    chk("model_mem_addr", 32'(mem_addr_a), 32'(ea));
    chk("model_rd_valid", 32'(rd_valid_a), 32'(ev));
    chk("model_busy", 32'(busy_a), 32'(eg != 0 || ev != 0));
    if (ev != 0) chk("model_rd_data", 32'(rd_data_a), 32'(idat[p]));
  end
  task automatic sa(input logic rs, input logic [3:0] r, input logic [3:0] l);
    @(posedge clk);
    #1;
    rst_a = rs;
    req_a = r;
    lock_a = l;
    @(negedge clk);
    #1;
  endtask
  task automatic sb(input logic rs, input logic [3:0] r);
    @(posedge clk);
    #1;
    rst_b = rs;
    req_b = r;
    @(negedge clk);
    #1;
  endtask
  logic [3:0] rr [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [3:0] ls [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2};
  initial begin
    sa(1, 4'hF, 4'h0);
    chk("rst_gnt", 32'(gnt_a), 0);
    chk("rst_rd_valid", 32'(rd_valid_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    for (int i = 0; i < 5; i++) begin
      sa(0, 4'hF, 4'h0);
      chk("rr_gnt", 32'(gnt_a), 32'(rr[i]));
      if (i > 0) chk("rr_rd_valid", 32'(rd_valid_a), 32'(rr[i-1]));
      if (i == 3) chk("rr_rd_data_req2", 32'(rd_data_a), 32'h0000_00ED);
    end
    sa(0, 4'h0, 4'h0);
    chk("rr_last_rd_valid", 32'(rd_valid_a), 1);
    chk("idle_gnt", 32'(gnt_a), 0);
    repeat (3) begin
      sa(0, 4'h4, 4'h0);
      chk("sparse_gnt2", 32'(gnt_a), 4);
    end
    sa(0, 4'h9, 4'h0);
    chk("sparse_gnt3", 32'(gnt_a), 8);
    sa(0, 4'h9, 4'h0);
    chk("sparse_gnt0", 32'(gnt_a), 1);
    sa(1, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      sa(0, 4'h3, 4'h1);
      chk("lock_gnt", 32'(gnt_a), 32'(ls[i]));
    end
    sa(0, 4'h8, 4'h0);
    chk("midrst_gnt3", 32'(gnt_a), 8);
    sa(1, 4'h8, 4'h0);
    chk("midrst_gnt_in_rst", 32'(gnt_a), 0);
    chk("midrst_rd_valid_in_rst", 32'(rd_valid_a), 0);
    repeat (3) begin
      sa(0, 4'h0, 4'h0);
      chk("midrst_no_return", 32'(rd_valid_a), 0);
    end
    sa(0, 4'hF, 4'h0);
    chk("midrst_next_gnt0", 32'(gnt_a), 1);
    sa(0, 4'h0, 4'h0);
    sb(1, 4'h0);
    sb(0, 4'h2);
    chk("lat2_gnt", 32'(gnt_b), 2);
    chk("lat2_busy_t", 32'(busy_b), 1);
    chk("lat2_rv_t", 32'(rd_valid_b), 0);
    sb(0, 4'h0);
    chk("lat2_rv_t1", 32'(rd_valid_b), 0);
    chk("lat2_busy_t1", 32'(busy_b), 1);
    sb(0, 4'h0);
    chk("lat2_rv_t2", 32'(rd_valid_b), 2);
    chk("lat2_busy_t2", 32'(busy_b), 1);
    chk("lat2_rd_data", 32'(rd_data_b), 32'h0000_00EE);
    sb(0, 4'h0);
    chk("lat2_rv_t3", 32'(rd_valid_b), 0);
    chk("lat2_busy_t3", 32'(busy_b), 0);
    sb(0, 4'h8);
    chk("lat2_midrst_gnt3", 32'(gnt_b), 8);
    sb(1, 4'h0);
    chk("lat2_midrst_gnt", 32'(gnt_b), 0);
    repeat (3) begin
      sb(0, 4'h0);
      chk("lat2_midrst_no_return", 32'(rd_valid_b), 0);
    end
    sb(0, 4'hF);
    chk("lat2_midrst_next_gnt0", 32'(gnt_b), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ct_read_arbiter.md
Name: ct_read_arbiter

Overview:
- Round-robin arbiter sharing one single-port, read-only ct_mem read port between N_REQ requesters.
- Requesters are crack cores, plus arc4 in the final decrypt pass; this removes the need for one ct_mem copy per core.
- Grants one read per cycle, forwards the winner's address to memory, and returns the read data RD_LAT cycles later with a per-requester valid strobe.
- Optional lock lets a requester hold the port for a burst, bounded by MAX_LOCK to prevent starvation.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, memory read latency in cycles (1 or 2).
- MAX_LOCK, 16, maximum consecutive grants to one locked requester.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  request bit per requester.
- lock  in  N_REQ  per requester: keep the grant next cycle if req is still high.
- addr  in  N_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the request.
- mem_addr  out  AW  address to ct_mem.
- mem_rddata  in  DW  ct_mem read data, valid RD_LAT cycles after its address.
- rd_data  out  DW  mem_rddata broadcast to all requesters.
- rd_valid  out  N_REQ  one-hot, high RD_LAT cycles after the matching gnt.
- busy  out  1  high when any read is in flight or any gnt is high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - last_id <= N_REQ-1, so requester 0 has first priority.
  - lock_cnt <= 0, lock_owner_valid <= 0.
  - Valid/id pipeline cleared.
  - While rst is high: gnt=0, mem_addr=0, rd_valid=0, busy=0, regardless of req.
  - Reads in flight when reset asserts are dropped; no rd_valid for them ever appears.
- Arbitration, combinational each cycle:
  - Locked case: lock_owner_valid, owner's req=1, owner's lock=1 and lock_cnt < MAX_LOCK. The owner wins.
  - Otherwise: the first i with req[i]=1, scanning last_id+1, last_id+2, … modulo N_REQ.
  - No req: gnt=0, mem_addr=0.
- Grant: gnt[w]=1 for the winner w only; mem_addr = addr[w] in the same cycle.
- State update on each grant:
  - last_id <= w.
  - If w equals the current owner and lock is honoured: lock_cnt <= lock_cnt+1.
  - Otherwise: lock_cnt <= 1.
  - lock_owner_valid <= lock[w]; owner <= w.
  - When lock_cnt reaches MAX_LOCK, the lock is ignored for one arbitration. Round-robin then applies from last_id+1, so the owner can win again only if no other requester is pending.
- State update on a cycle with no grant: lock_owner_valid <= 0, lock_cnt <= 0; last_id is held.
- Read pipeline:
  - RD_LAT-stage shift register of {valid, id}.
  - Stage 0 loads {|gnt, w} each cycle.
  - rd_valid = onehot(id) & valid at the final stage.
  - rd_data = mem_rddata, combinational passthrough.
- Throughput: one read per cycle. Back-to-back grants to different requesters are allowed, and their returns are ordered identically.
- Requester contract:
  - Holds req and addr stable until it sees gnt.
  - May drop req the cycle after gnt.
  - Must capture rd_data in the cycle rd_valid is high; the arbiter does not hold it.
- Width rules: no arithmetic on addresses. lock_cnt is clog2(MAX_LOCK+1) bits and saturates at MAX_LOCK.
- busy = |gnt | (any pipeline valid).

Test Plan:
- Reset: rst=1 with req=4'b1111 → gnt=0, rd_valid=0, busy=0. After releasing rst, first cycle → gnt=4'b0001.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, lock=0, addr_i=8'h10+i, memory returns data=addr^8'hFF, RD_LAT=1.
  - Grants rotate 0,1,2,3,0.
  - rd_valid arrives one cycle after each gnt, same rotation; the return for requester 2 has rd_data=8'hED.
- Sparse requests: only req[2] high for 3 cycles, then req[0] and req[3] together.
  - gnt[2] three times.
  - Then gnt[3], then gnt[0] (scan starts after last_id=2).
- Lock bound: MAX_LOCK=4, req=4'b0011, lock=4'b0001 → gnt sequence 0,0,0,0,1,0,0,0,0,1.
- Latency 2: RD_LAT=2, single request from requester 1 at cycle t → rd_valid=4'b0010 exactly at t+2; busy high for t..t+2.
- Reset mid-flight: grant requester 3 at cycle t, rst=1 at t+1 → no rd_valid in any later cycle; next grant after reset goes to requester 0.
